// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifu_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_HOLD = 3'd3,
      S_STOP = 3'd4
   } ifu_state_e;

   localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;
   localparam int          BUF_W         = 65;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        misalign;
   } ifu_entry_t;

   function automatic logic [31:0] jump_target(input logic [31:0] raw);
      return raw & 32'hFFFF_FFFE;
   endfunction

endpackage

// File: rtl/ifu_out_buf.sv
// One-entry registered valid/ready buffer; load wins over flush and fire.
module ifu_out_buf #(
   parameter int W = 65
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic         i_flush,
   input  logic [W-1:0] i_data,
   input  logic         i_ready,
   output logic         o_valid,
   output logic [W-1:0] o_data
);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid <= 1'b0;
         o_data  <= '0;
      end else if (i_load) begin
         o_valid <= 1'b1;
         o_data  <= i_data;
      end else if (i_flush || (o_valid && i_ready)) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ifu_pc_fetch.sv
// Fetch front end: owns the PC, single-outstanding imem requests,
// redirect handling and delivery of {pc, instr} to decode.
module ifu_pc_fetch import ifu_pkg::*; #(
   parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
   parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_jump_en,
   input  logic [31:0] i_jump_addr,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic        o_ifu_valid,
   input  logic        i_ifu_ready,
   output logic [31:0] o_ifu_pc,
   output logic [31:0] o_ifu_instr,
   output logic        o_ifu_misalign
);

   ifu_state_e  state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        kill_q, kill_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] skid_instr_q, skid_instr_d;

   ifu_entry_t  buf_din, buf_dout;
   logic        buf_load, buf_flush, buf_valid;
   logic        fire, pending;
   logic [31:0] target;

   assign fire   = buf_valid && i_ifu_ready;
   assign target = jump_target(i_jump_addr);

   // A response is still owed after this edge unless it lands now.
   assign pending =
      (((state_q == S_WAIT) || ((state_q == S_STOP) && kill_q))
        && !i_imem_rvalid)
      || ((state_q == S_REQ) && i_imem_gnt);

   assign o_imem_req  = (state_q == S_REQ);
   assign o_imem_addr = o_imem_req ? (fetch_pc_q & 32'hFFFF_FFFC) : '0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= S_IDLE;
         fetch_pc_q   <= RESET_PC;
         req_pc_q     <= '0;
         kill_q       <= 1'b0;
         skid_pc_q    <= '0;
         skid_instr_q <= '0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         req_pc_q     <= req_pc_d;
         kill_q       <= kill_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      req_pc_d     = req_pc_q;
      kill_d       = kill_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      buf_load     = 1'b0;
      buf_flush    = 1'b0;
      buf_din      = '0;

      if (i_jump_en) begin
         buf_flush  = 1'b1;
         fetch_pc_d = target;
         if (target[1]) begin
            buf_load = 1'b1;
            buf_din  = '{pc: target, instr: NOP_INSTR, misalign: 1'b1};
            state_d  = S_STOP;
            kill_d   = pending;
         end else if (pending) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
         end else begin
            state_d = S_REQ;
            kill_d  = 1'b0;
         end
      end else begin
         unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
               if (i_imem_gnt) begin
                  state_d    = S_WAIT;
                  req_pc_d   = fetch_pc_q;
                  fetch_pc_d = fetch_pc_q + 32'd4;
               end
            end
            S_WAIT: begin
               if (i_imem_rvalid) begin
                  if (kill_q) begin
                     kill_d  = 1'b0;
                     state_d = S_REQ;
                  end else if (!buf_valid || fire) begin
                     buf_load = 1'b1;
                     buf_din  = '{pc: req_pc_q, instr: i_imem_rdata,
                                  misalign: 1'b0};
                     state_d  = S_REQ;
                  end else begin
                     // Decode is stalled: park the word until the slot frees.
                     skid_pc_d    = req_pc_q;
                     skid_instr_d = i_imem_rdata;
                     state_d      = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (fire) begin
                  buf_load = 1'b1;
                  buf_din  = '{pc: skid_pc_q, instr: skid_instr_q,
                               misalign: 1'b0};
                  state_d  = S_REQ;
               end
            end
            S_STOP: begin
               if (i_imem_rvalid && kill_q) kill_d = 1'b0;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   ifu_out_buf #(.W(BUF_W)) u_buf (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (buf_load),
      .i_flush (buf_flush),
      .i_data  (buf_din),
      .i_ready (i_ifu_ready),
      .o_valid (buf_valid),
      .o_data  (buf_dout)
   );

   assign o_ifu_valid    = buf_valid;
   assign o_ifu_pc       = buf_dout.pc;
   assign o_ifu_instr    = buf_dout.instr;
   assign o_ifu_misalign = buf_dout.misalign;

endmodule
